// File: rtl/aes_pkg.sv
// Shared constants and byte-index helpers for the Rijndael round datapath.
// Byte (r,c) of a column-major state sits at byte position ROWS*c + r, counted from the MSB end.
package aes_pkg;
    localparam int BYTE_W = 8;
    localparam int ROWS   = 4;

    // Row rotation amounts; the 8-column block widens the gaps for rows 2 and 3.
    function automatic int shift_amt(input int nb, input int row);
        int amt;
        amt = row;
        if (nb == 8 && row >= 2) amt = row + 1;
        return amt;
    endfunction

    function automatic int byte_idx(input int r, input int c);
        return ROWS * c + r;
    endfunction
endpackage

// File: rtl/pipe_slice.sv
// Single-entry valid/ready register slice: full throughput, no bubbles, full backpressure.
module pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);
    logic         valid_q;
    logic [W-1:0] data_q;

    // Handshake: a beat moves on a rising edge where valid and ready are both high.
    // The slice accepts whenever it is empty or its current beat leaves this cycle,
    // so a simultaneous load and unload simply replaces the contents.
    assign ready_o = !valid_q || ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else if (valid_i && ready_o) begin
            valid_q <= 1'b1;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Payload is don't-care while empty, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (valid_i && ready_o) begin
            data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/shift_rows_pipe.sv
// Rijndael ShiftRows / InvShiftRows stage for 4, 6 or 8 columns, with a chain of
// valid/ready register slices carrying {tag, state}.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              inv_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [32*NB-1:0]  state_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [TAG_W-1:0]  tag_o,
    output logic [32*NB-1:0]  state_o
);
    localparam int W  = 32 * NB;
    localparam int BW = TAG_W + W;

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 0 || STAGES > 2) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be 0, 1 or 2");
    end

    logic [W-1:0] shifted;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int SH     = shift_amt(NB, r);
            localparam int FWD_C  = (c + SH) % NB;
            localparam int INV_C  = (c - SH + NB) % NB;
            localparam int DST_HI = W - 1 - BYTE_W * byte_idx(r, c);
            localparam int FWD_HI = W - 1 - BYTE_W * byte_idx(r, FWD_C);
            localparam int INV_HI = W - 1 - BYTE_W * byte_idx(r, INV_C);

            assign shifted[DST_HI -: BYTE_W] = inv_i ? state_i[INV_HI -: BYTE_W]
                                                     : state_i[FWD_HI -: BYTE_W];
        end
    end

    // Index s is the link feeding slice s; link STAGES is the module output.
    logic [STAGES:0] link_valid;
    logic [STAGES:0] link_ready;
    logic [BW-1:0]   link_data [STAGES+1];

    assign link_valid[0]      = valid_i;
    assign link_data[0]       = {tag_i, shifted};
    assign ready_o            = link_ready[0];
    assign link_ready[STAGES] = ready_i;
    assign valid_o            = link_valid[STAGES];
    assign {tag_o, state_o}   = link_data[STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_slice
        pipe_slice #(.W(BW)) u_slice (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .valid_i (link_valid[s]),
            .ready_o (link_ready[s]),
            .data_i  (link_data[s]),
            .valid_o (link_valid[s+1]),
            .ready_i (link_ready[s+1]),
            .data_o  (link_data[s+1])
        );
    end

    if (STAGES == 0) begin : g_comb
        // Pure pass-through: clock and reset have nothing to drive.
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
    end
endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: four instances (NB4/1 slice, NB8/1 slice, NB4/2 slices, NB4/comb).
module tb_shift_rows_pipe;
    typedef logic [259:0] cmp_t;

    typedef struct {
        logic         inv;
        logic [3:0]   tag;
        logic [127:0] st;
        logic [127:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic         a_valid_i, a_ready_o, a_inv_i, a_valid_o, a_ready_i;
    logic [3:0]   a_tag_i, a_tag_o;
    logic [127:0] a_state_i, a_state_o;

    logic         b_valid_i, b_ready_o, b_inv_i, b_valid_o, b_ready_i;
    logic [3:0]   b_tag_i, b_tag_o;
    logic [255:0] b_state_i, b_state_o;

    logic         c_valid_i, c_ready_o, c_inv_i, c_valid_o, c_ready_i;
    logic [3:0]   c_tag_i, c_tag_o;
    logic [127:0] c_state_i, c_state_o;

    logic         d_valid_i, d_ready_o, d_inv_i, d_valid_o, d_ready_i;
    logic [3:0]   d_tag_i, d_tag_o;
    logic [127:0] d_state_i, d_state_o;

    logic [131:0] exp_q[$];
    int           c_seen = 0;
    logic         c_stall_seen = 1'b0;

    shift_rows_pipe #(.NB(4), .STAGES(1), .TAG_W(4)) u_a (
        .clk_i(clk), .rst_i(rst), .valid_i(a_valid_i), .ready_o(a_ready_o), .inv_i(a_inv_i),
        .tag_i(a_tag_i), .state_i(a_state_i), .valid_o(a_valid_o), .ready_i(a_ready_i),
        .tag_o(a_tag_o), .state_o(a_state_o));

    shift_rows_pipe #(.NB(8), .STAGES(1), .TAG_W(4)) u_b (
        .clk_i(clk), .rst_i(rst), .valid_i(b_valid_i), .ready_o(b_ready_o), .inv_i(b_inv_i),
        .tag_i(b_tag_i), .state_i(b_state_i), .valid_o(b_valid_o), .ready_i(b_ready_i),
        .tag_o(b_tag_o), .state_o(b_state_o));

    shift_rows_pipe #(.NB(4), .STAGES(2), .TAG_W(4)) u_c (
        .clk_i(clk), .rst_i(rst), .valid_i(c_valid_i), .ready_o(c_ready_o), .inv_i(c_inv_i),
        .tag_i(c_tag_i), .state_i(c_state_i), .valid_o(c_valid_o), .ready_i(c_ready_i),
        .tag_o(c_tag_o), .state_o(c_state_o));

    shift_rows_pipe #(.NB(4), .STAGES(0), .TAG_W(4)) u_d (
        .clk_i(clk), .rst_i(rst), .valid_i(d_valid_i), .ready_o(d_ready_o), .inv_i(d_inv_i),
        .tag_i(d_tag_i), .state_i(d_state_i), .valid_o(d_valid_o), .ready_i(d_ready_i),
        .tag_o(d_tag_o), .state_o(d_state_o));

    task automatic check(input string name, input cmp_t act, input cmp_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each row is rotated one byte at a time, left for forward, right for inverse.
    function automatic logic [255:0] model(input int nb, input logic inv, input logic [255:0] s);
        logic [255:0] o;
        logic [7:0]   row [8];
        logic [7:0]   t;
        int           hi;
        int           sh;
        o  = '0;
        hi = 32 * nb - 1;
        for (int r = 0; r < 4; r++) begin
            case (r)
                0:       sh = 0;
                1:       sh = 1;
                2:       sh = (nb == 8) ? 3 : 2;
                default: sh = (nb == 8) ? 4 : 3;
            endcase
            for (int c = 0; c < nb; c++) row[c] = s[hi - 8 * (4 * c + r) -: 8];
            repeat (sh) begin
                if (!inv) begin
                    t = row[0];
                    for (int c = 0; c < nb - 1; c++) row[c] = row[c + 1];
                    row[nb - 1] = t;
                end else begin
                    t = row[nb - 1];
                    for (int c = nb - 1; c > 0; c--) row[c] = row[c - 1];
                    row[0] = t;
                end
            end
            for (int c = 0; c < nb; c++) o[hi - 8 * (4 * c + r) -: 8] = row[c];
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
    task automatic send_c(input logic [3:0] tag, input logic inv, input logic [127:0] st);
        logic [255:0] m;
        int           n;
        logic         accepted;
        m        = model(4, inv, {128'b0, st});
        n        = 0;
        accepted = 1'b0;
        c_valid_i = 1'b1;
        c_tag_i   = tag;
        c_inv_i   = inv;
        c_state_i = st;
        while (!accepted && n < 100) begin
            @(negedge clk);
            if (c_ready_o) begin
                accepted = 1'b1;
                exp_q.push_back({tag, m[127:0]});
            end
            n++;
            @(posedge clk);
            #1;
        end
        c_valid_i = 1'b0;
        if (!accepted) check("c_send_accept", cmp_t'(accepted), cmp_t'(1));
    endtask

    task automatic drain_c(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, cmp_t'(exp_q.size()), cmp_t'(0));
    endtask

    // Output-side scoreboard and hold-stability monitor for the two-slice instance.
    initial begin
        logic         prev_stall;
        logic [131:0] prev_data;
        logic [131:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (!c_ready_o) c_stall_seen = 1'b1;
                if (prev_stall) begin
                    check("c_hold_valid", cmp_t'(c_valid_o), cmp_t'(1));
                    check("c_hold_data", cmp_t'({c_tag_o, c_state_o}), cmp_t'(prev_data));
                end
                if (c_valid_o && c_ready_i) begin
                    check("c_beat_expected", cmp_t'(exp_q.size() != 0), cmp_t'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("c_tag", cmp_t'(c_tag_o), cmp_t'(e[131:128]));
                        check("c_state", cmp_t'(c_state_o), cmp_t'(e[127:0]));
                        c_seen++;
                    end
                end
                prev_stall = c_valid_o && !c_ready_i;
                prev_data  = {c_tag_o, c_state_o};
            end
        end
    end

    initial begin
        vec_t         vecs[6];
        logic [255:0] m;
        logic [255:0] walk;
        logic [255:0] walk_fwd;
        int           seen0;
        logic         done;

        vecs[0] = '{1'b0, 4'h3, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230,
                    128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
        vecs[1] = '{1'b1, 4'h7, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5,
                    128'hd42711ae_e0bf98f1_b8b45de5_1e415230};
        vecs[2] = '{1'b0, 4'ha, {16{8'ha5}}, {16{8'ha5}}};
        for (int i = 3; i < 6; i++) begin
            vecs[i].inv = 1'(i % 2);
            vecs[i].tag = 4'(i);
            vecs[i].st  = rand128();
            m = model(4, vecs[i].inv, {128'b0, vecs[i].st});
            vecs[i].exp = m[127:0];
        end

        rst = 1'b1;
        {a_valid_i, a_inv_i, a_tag_i, a_state_i} = '0;
        {b_valid_i, b_inv_i, b_tag_i, b_state_i} = '0;
        {c_valid_i, c_inv_i, c_tag_i, c_state_i} = '0;
        {d_valid_i, d_inv_i, d_tag_i, d_state_i} = '0;
        a_ready_i = 1'b1;
        b_ready_i = 1'b1;
        c_ready_i = 1'b1;
        d_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("a_reset_valid", cmp_t'(a_valid_o), cmp_t'(0));
        check("a_reset_ready", cmp_t'(a_ready_o), cmp_t'(1));
        check("b_reset_valid", cmp_t'(b_valid_o), cmp_t'(0));
        check("c_reset_valid", cmp_t'(c_valid_o), cmp_t'(0));
        check("c_reset_ready", cmp_t'(c_ready_o), cmp_t'(1));

        // One-slice NB=4: each vector must appear exactly one cycle after it is accepted.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            a_valid_i = 1'b1;
            a_inv_i   = vecs[i].inv;
            a_tag_i   = vecs[i].tag;
            a_state_i = vecs[i].st;
            @(posedge clk);
            #1;
            a_valid_i = 1'b0;
            check("a_valid", cmp_t'(a_valid_o), cmp_t'(1));
            check("a_state", cmp_t'(a_state_o), cmp_t'(vecs[i].exp));
            check("a_tag", cmp_t'(a_tag_o), cmp_t'(vecs[i].tag));
        end
        @(posedge clk);
        #1;
        check("a_idle_after", cmp_t'(a_valid_o), cmp_t'(0));

        // NB=8 with byte k = k. Column 0 is 00 05 0e 13; column 7 takes row 3 from column 3 (0x0f).
        for (int k = 0; k < 32; k++) walk[255 - 8 * k -: 8] = 8'(k);
        walk_fwd = model(8, 1'b0, walk);
        b_valid_i = 1'b1;
        b_inv_i   = 1'b0;
        b_tag_i   = 4'h9;
        b_state_i = walk;
        @(posedge clk);
        #1;
        b_valid_i = 1'b0;
        check("b_valid", cmp_t'(b_valid_o), cmp_t'(1));
        check("b_fwd_state", cmp_t'(b_state_o), cmp_t'(walk_fwd));
        check("b_fwd_col0", cmp_t'(b_state_o[255:224]), cmp_t'(32'h00050e13));
        check("b_fwd_col7", cmp_t'(b_state_o[31:0]), cmp_t'(32'h1c010a0f));
        check("b_tag", cmp_t'(b_tag_o), cmp_t'(4'h9));
        b_valid_i = 1'b1;
        b_inv_i   = 1'b1;
        b_state_i = walk_fwd;
        @(posedge clk);
        #1;
        b_valid_i = 1'b0;
        check("b_inv_state", cmp_t'(b_state_o), cmp_t'(walk));

        // Combinational instance: ready and data follow the inputs within the cycle.
        for (int i = 0; i < 8; i++) begin
            d_ready_i = 1'(i % 2);
            d_valid_i = 1'($urandom_range(0, 1));
            d_inv_i   = 1'b0;
            d_tag_i   = 4'(i);
            d_state_i = rand128();
            m = model(4, 1'b0, {128'b0, d_state_i});
            @(negedge clk);
            check("d_ready", cmp_t'(d_ready_o), cmp_t'(d_ready_i));
            check("d_valid", cmp_t'(d_valid_o), cmp_t'(d_valid_i));
            check("d_state", cmp_t'(d_state_o), cmp_t'(m[127:0]));
            check("d_tag", cmp_t'(d_tag_o), cmp_t'(4'(i)));
            @(posedge clk);
            #1;
        end

        // Two slices: six back-to-back beats, downstream stalled for cycles 2..6.
        seen0 = c_seen;
        c_stall_seen = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_c(4'(i), 1'b0, rand128());
            end
            begin
                for (int cyc = 0; cyc < 7; cyc++) begin
                    c_ready_i = !(cyc >= 2 && cyc <= 6);
                    @(negedge clk);
                    if (cyc == 4) check("c_ready_full", cmp_t'(c_ready_o), cmp_t'(0));
                    @(posedge clk);
                    #1;
                end
                c_ready_i = 1'b1;
            end
        join
        drain_c("c_bp_drain");
        check("c_bp_count", cmp_t'(c_seen - seen0), cmp_t'(6));
        check("c_bp_stalled", cmp_t'(c_stall_seen), cmp_t'(1));

        // Random gaps on both sides.
        seen0 = c_seen;
        done  = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send_c(4'(i), 1'($urandom_range(0, 1)), rand128());
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    c_ready_i = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                c_ready_i = 1'b1;
            end
        join
        drain_c("c_rand_drain");
        check("c_rand_count", cmp_t'(c_seen - seen0), cmp_t'(40));

        // Reset with both slices full; a beat offered during reset must not be captured.
        c_ready_i = 1'b0;
        send_c(4'hc, 1'b0, rand128());
        send_c(4'hd, 1'b1, rand128());
        @(negedge clk);
        check("c_full_before_rst", cmp_t'(c_valid_o), cmp_t'(1));
        @(posedge clk);
        #1;
        rst       = 1'b1;
        c_valid_i = 1'b1;
        c_tag_i   = 4'he;
        c_state_i = rand128();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        c_valid_i = 1'b0;
        check("c_rst_valid", cmp_t'(c_valid_o), cmp_t'(0));
        check("c_rst_ready", cmp_t'(c_ready_o), cmp_t'(1));
        c_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("c_no_stale", cmp_t'(c_valid_o), cmp_t'(0));
        end
        @(posedge clk);
        #1;
        seen0 = c_seen;
        send_c(4'h5, 1'b0, rand128());
        drain_c("c_post_rst_drain");
        check("c_post_rst_count", cmp_t'(c_seen - seen0), cmp_t'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
